// File: rtl/ifetch_buf_if.sv
// Fetch-buffer bus bundle: instruction-memory handshake, redirect, consumer pop and status.
interface ifetch_buf_if #(
   parameter int unsigned DATA_W = 16
);
   logic              imem_req;
   logic [DATA_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_data;
   logic              redirect;
   logic [DATA_W-1:0] redirect_pc;
   logic              deq;
   logic              out_valid;
   logic [DATA_W-1:0] out_instr;
   logic [DATA_W-1:0] out_pc;
   logic              halted;
   logic              err;

   // slave: the fetch buffer itself
   modport slave (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, halted, err,
      input  imem_ack, imem_data, redirect, redirect_pc, deq
   );

   // master: memory / pipeline side driving the fetch buffer
   modport master (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, halted, err,
      output imem_ack, imem_data, redirect, redirect_pc, deq
   );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: one-outstanding fetch engine feeding a circular {instr, pc} FIFO,
// with redirect flush, halt detection and a sticky protocol-error flag.
module ifetch_buf #(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int unsigned       INC      = 2,
   parameter logic [4:0]        HALT_OPC = 5'b00000
) (
   input logic         clk,
   input logic         rst,
   ifetch_buf_if.slave bus
);

   localparam int unsigned PTR_W    = $clog2(DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam bit          INC_EVEN = ((INC % 2) == 0);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] instr_q [DEPTH];
   logic [DATA_W-1:0] pcs_q   [DEPTH];

   logic              req_c;
   logic [DATA_W-1:0] addr_c;
   logic              enq_c;
   logic              deq_c;
   logic              is_halt_c;
   logic              err_cond_c;

   // DRAIN keeps presenting the abandoned address until its response arrives
   assign req_c  = !rst && (((state_q == ST_RUN) && (cnt_q < CNT_W'(DEPTH))) ||
                            (state_q == ST_DRAIN));
   assign addr_c = (state_q == ST_DRAIN) ? hold_q : pc_q;

   assign enq_c      = req_c && bus.imem_ack && !bus.redirect && (state_q == ST_RUN);
   assign deq_c      = !rst && bus.deq && (cnt_q != '0) && !bus.redirect;
   assign is_halt_c  = (bus.imem_data[DATA_W-1 -: 5] == HALT_OPC);
   assign err_cond_c = (bus.deq && (cnt_q == '0) && !bus.redirect) ||
                       (bus.imem_ack && !req_c) ||
                       (bus.redirect && bus.redirect_pc[0] && INC_EVEN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         hold_q  <= RESET_PC;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_c) begin
         instr_q[wr_q] <= bus.imem_data;
         pcs_q[wr_q]   <= pc_q;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (bus.redirect) begin
         // flush wins over this cycle's enqueue/dequeue
         wr_d    = '0;
         rd_d    = '0;
         cnt_d   = '0;
         pc_d    = bus.redirect_pc;
         hold_d  = addr_c;
         state_d = (req_c && !bus.imem_ack) ? ST_DRAIN : ST_RUN;
      end else begin
         if (enq_c) begin
            wr_d = wr_q + PTR_W'(1);
            pc_d = pc_q + DATA_W'(INC);
         end
         if (deq_c) begin
            rd_d = rd_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(enq_c) - CNT_W'(deq_c);
         case (state_q)
            ST_RUN:   if (enq_c && is_halt_c) state_d = ST_HALT;
            ST_DRAIN: if (bus.imem_ack) state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end

      if (err_cond_c) begin
         err_d = 1'b1;
      end
   end

   assign bus.imem_req  = req_c;
   assign bus.imem_addr = addr_c;
   assign bus.out_valid = !rst && (cnt_q != '0);
   assign bus.out_instr = instr_q[rd_q];
   assign bus.out_pc    = pcs_q[rd_q];
   assign bus.halted    = !rst && (state_q == ST_HALT) && (cnt_q == '0);
   assign bus.err       = !rst && err_q;

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed self-checking bench for ifetch_buf (DATA_W=16, DEPTH=4, RESET_PC=0, INC=2).
module tb_ifetch_buf;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   ifetch_buf_if #(.DATA_W(16)) bus ();

   ifetch_buf #(
      .DATA_W  (16),
      .DEPTH   (4),
      .RESET_PC(16'h0000),
      .INC     (2),
      .HALT_OPC(5'b00000)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // advance one edge; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.imem_ack    = 1'b0;
      bus.imem_data   = 16'h0000;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.deq         = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      // reset state
      chk("rst_req",    32'(bus.imem_req),  32'd0);
      chk("rst_valid",  32'(bus.out_valid), 32'd0);
      chk("rst_halted", 32'(bus.halted),    32'd0);
      chk("rst_err",    32'(bus.err),       32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_req",  32'(bus.imem_req),  32'd1);
      chk("post_rst_addr", 32'(bus.imem_addr), 32'h0000);

      // fill with zero-wait memory, no dequeue
      for (int n = 0; n < 4; n++) begin
         chk("fill_req",  32'(bus.imem_req),  32'd1);
         chk("fill_addr", 32'(bus.imem_addr), 32'(2 * n));
         bus.imem_ack  = 1'b1;
         bus.imem_data = 16'(16'h1000 + n);
         tick();
      end
      idle_inputs();
      chk("full_req",   32'(bus.imem_req),  32'd0);
      chk("full_valid", 32'(bus.out_valid), 32'd1);
      chk("full_pc",    32'(bus.out_pc),    32'h0000);
      chk("full_instr", 32'(bus.out_instr), 32'h1000);
      tick();
      chk("full_hold_req", 32'(bus.imem_req), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(bus.out_valid), 32'd1);
         chk("drain_pc",    32'(bus.out_pc),    32'(2 * k));
         chk("drain_instr", 32'(bus.out_instr), 32'(16'h1000 + k));
         bus.deq = 1'b1;
         tick();
      end
      bus.deq = 1'b0;
      chk("empty_valid", 32'(bus.out_valid), 32'd0);
      chk("empty_addr",  32'(bus.imem_addr), 32'h0008);
      chk("empty_err",   32'(bus.err),       32'd0);

      // streaming: enqueue and dequeue every cycle, pointers wrap
      do_reset();
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h1000;
      tick();
      for (int k = 0; k < 6; k++) begin
         chk("strm_valid", 32'(bus.out_valid), 32'd1);
         chk("strm_pc",    32'(bus.out_pc),    32'(2 * k));
         chk("strm_instr", 32'(bus.out_instr), 32'(16'h1000 + k));
         chk("strm_req",   32'(bus.imem_req),  32'd1);
         chk("strm_addr",  32'(bus.imem_addr), 32'(2 * (k + 1)));
         bus.imem_ack  = 1'b1;
         bus.imem_data = 16'(16'h1000 + k + 1);
         bus.deq       = 1'b1;
         tick();
      end
      idle_inputs();
      chk("strm_err", 32'(bus.err), 32'd0);

      // ack delayed two cycles; redirect while 0x0006 is outstanding
      do_reset();
      for (int n = 0; n < 3; n++) begin
         tick();
         tick();
         chk("dly_addr_stable", 32'(bus.imem_addr), 32'(2 * n));
         bus.imem_ack  = 1'b1;
         bus.imem_data = 16'(16'h1000 + n);
         tick();
         bus.imem_ack  = 1'b0;
      end
      tick();
      chk("dly_pre_addr", 32'(bus.imem_addr), 32'h0006);
      chk("dly_pre_cnt",  32'(bus.out_valid), 32'd1);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0040;
      tick();
      bus.redirect = 1'b0;
      chk("redir_valid",    32'(bus.out_valid), 32'd0);
      chk("drain_req",      32'(bus.imem_req),  32'd1);
      chk("drain_addr_old", 32'(bus.imem_addr), 32'h0006);
      tick();
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h1003;
      tick();
      bus.imem_ack = 1'b0;
      chk("discard_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_addr",    32'(bus.imem_addr), 32'h0040);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h2000;
      tick();
      chk("redir_pc",    32'(bus.out_pc),    32'h0040);
      chk("redir_instr", 32'(bus.out_instr), 32'h2000);
      // redirect with a simultaneous ack: no drain, PC wraps past 0xFFFE
      bus.imem_ack    = 1'b1;
      bus.imem_data   = 16'h3000;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFE;
      tick();
      bus.redirect = 1'b0;
      chk("rack_valid", 32'(bus.out_valid), 32'd0);
      chk("rack_addr",  32'(bus.imem_addr), 32'hFFFE);
      bus.imem_data = 16'h3001;
      tick();
      idle_inputs();
      chk("wrap_pc",    32'(bus.out_pc),    32'hFFFE);
      chk("wrap_instr", 32'(bus.out_instr), 32'h3001);
      chk("wrap_addr",  32'(bus.imem_addr), 32'h0000);
      chk("wrap_err",   32'(bus.err),       32'd0);

      // halt instruction fetched at PC 4
      do_reset();
      for (int n = 0; n < 3; n++) begin
         bus.imem_ack  = 1'b1;
         bus.imem_data = (n == 2) ? 16'h0000 : 16'(16'h1000 + n);
         tick();
      end
      idle_inputs();
      chk("halt_req",    32'(bus.imem_req), 32'd0);
      chk("halt_nodrn",  32'(bus.halted),   32'd0);
      tick();
      chk("halt_req2",   32'(bus.imem_req), 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("halt_deq_pc", 32'(bus.out_pc), 32'(2 * k));
         bus.deq = 1'b1;
         tick();
      end
      bus.deq = 1'b0;
      chk("halted",      32'(bus.halted),    32'd1);
      chk("halt_valid",  32'(bus.out_valid), 32'd0);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0010;
      tick();
      bus.redirect = 1'b0;
      chk("unhalt_req",    32'(bus.imem_req),  32'd1);
      chk("unhalt_addr",   32'(bus.imem_addr), 32'h0010);
      chk("unhalt_halted", 32'(bus.halted),    32'd0);

      // sticky error: deq on empty
      bus.deq = 1'b1;
      tick();
      bus.deq = 1'b0;
      chk("err_deq_empty", 32'(bus.err), 32'd1);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h1234;
      tick();
      idle_inputs();
      chk("err_sticky",  32'(bus.err),       32'd1);
      chk("err_traffic", 32'(bus.out_instr), 32'h1234);
      rst = 1'b1;
      tick();
      chk("err_in_rst", 32'(bus.err), 32'd0);
      rst = 1'b0;
      tick();
      chk("err_cleared", 32'(bus.err), 32'd0);
      for (int n = 0; n < 4; n++) begin
         bus.imem_ack  = 1'b1;
         bus.imem_data = 16'(16'h1000 + n);
         tick();
      end
      chk("err_full_req", 32'(bus.imem_req), 32'd0);
      chk("err_full_clr", 32'(bus.err),      32'd0);
      tick();
      bus.imem_ack = 1'b0;
      chk("err_ack_noreq", 32'(bus.err),    32'd1);
      chk("err_nopush_pc", 32'(bus.out_pc), 32'h0000);

      // odd redirect target
      do_reset();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0011;
      tick();
      bus.redirect = 1'b0;
      chk("err_odd_redir", 32'(bus.err), 32'd1);

      // reset with an outstanding request and an ack in the same cycle
      do_reset();
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h1000;
      tick();
      bus.imem_ack = 1'b0;
      chk("rr_pre_addr", 32'(bus.imem_addr), 32'h0002);
      rst           = 1'b1;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h1111;
      tick();
      chk("rr_in_req",   32'(bus.imem_req),  32'd0);
      chk("rr_in_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      idle_inputs();
      tick();
      chk("rr_valid", 32'(bus.out_valid), 32'd0);
      chk("rr_req",   32'(bus.imem_req),  32'd1);
      chk("rr_addr",  32'(bus.imem_addr), 32'h0000);
      chk("rr_err",   32'(bus.err),       32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
